// File: rtl/systolic_skew_buffer_if.sv
// Operand/result bus between the upstream buffer, the skew buffer and the PE grid.
// master drives the input beat and controls; slave is the skew buffer.
interface systolic_skew_buffer_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 16
);
  logic                   en;
  logic                   clear;
  logic                   in_valid;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   busy;

  modport master (
    output en, clear, in_valid, in_data,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  en, clear, in_valid, in_data,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/systolic_skew_buffer.sv
// Per-lane delay line that skews (MODE 0) or deskews (MODE 1) a parallel vector
// for a systolic array; bubbles are zero-filled, with stall and synchronous flush.
module systolic_skew_buffer #(
  parameter int WIDTH      = 16,
  parameter int LANES      = 4,
  parameter int BASE_DELAY = 1,
  parameter int MODE       = 0
) (
  input logic                  clk,
  input logic                  reset,
  systolic_skew_buffer_if.slave bus
);

  if (LANES < 1) begin : g_bad_lanes
    $error("systolic_skew_buffer: LANES must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("systolic_skew_buffer: WIDTH must be >= 1");
  end
  if (BASE_DELAY < 0) begin : g_bad_delay
    $error("systolic_skew_buffer: BASE_DELAY must be >= 0");
  end

  logic [LANES-1:0]       lane_valid;
  logic [LANES*WIDTH-1:0] lane_data;
  logic [LANES-1:0]       lane_busy_d;
  logic                   busy_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int D = (MODE == 1) ? BASE_DELAY + (LANES - 1 - i) : BASE_DELAY + i;

    // Bubbles always carry zero data into the grid.
    logic [WIDTH-1:0] cap_data;
    assign cap_data = bus.in_valid ? bus.in_data[i*WIDTH +: WIDTH] : '0;

    if (D == 0) begin : g_pass
      assign lane_valid[i]                 = bus.in_valid;
      assign lane_data[i*WIDTH +: WIDTH]   = cap_data;
      assign lane_busy_d[i]                = 1'b0;
    end else begin : g_pipe
      logic [D-1:0]            v_q;
      logic [D-1:0]            v_d;
      logic [D-1:0][WIDTH-1:0] d_q;
      logic [D-1:0][WIDTH-1:0] d_d;

      // Clear beats enable; stall holds every stage.
      always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (bus.clear) begin
          v_d = '0;
          d_d = '0;
        end else if (bus.en) begin
          v_d[0] = bus.in_valid;
          d_d[0] = cap_data;
          for (int k = 1; k < D; k++) begin
            v_d[k] = v_q[k-1];
            d_d[k] = d_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_q <= '0;
          d_q <= '0;
        end else begin
          v_q <= v_d;
          d_q <= d_d;
        end
      end

      assign lane_valid[i]               = v_q[D-1];
      assign lane_data[i*WIDTH +: WIDTH] = d_q[D-1];
      assign lane_busy_d[i]              = |v_d;
    end
  end

  // busy tracks the OR of stage valids by registering its next-state value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= |lane_busy_d;
    end
  end

  assign bus.out_valid = lane_valid;
  assign bus.out_data  = lane_data;
  assign bus.busy      = busy_q;

endmodule
